// File: rtl/seq_divider.sv
// 16-by-8 sequential restoring divider: one quotient bit per cycle, MSB first.
// Define DIV_SIGNED_EN for two's-complement operands (magnitude divide plus sign fix-up).
module seq_divider (
    input  logic        clk,
    input  logic        cr,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_zero,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [8:0]  prem;
    logic [15:0] qsr;
    logic [7:0]  dvs;
    logic [4:0]  cnt;

    logic [15:0] a_mag;
    logic [7:0]  b_mag;
    logic [8:0]  shifted;
    logic        fits;
    logic [8:0]  prem_step;
    logic [15:0] qsr_step;
    logic [15:0] q_final;
    logic [7:0]  r_final;
    logic        accept;
    logic        last;

`ifdef DIV_SIGNED_EN
    logic        neg_q;
    logic        neg_r;
`endif

    assign accept    = (state == IDLE) && start;
    assign last      = (cnt == 5'd15);
    assign dbg_state = state;

    // Operand magnitudes fed into the unsigned core.
    always_comb begin
        a_mag = dividend;
        b_mag = divisor;
`ifdef DIV_SIGNED_EN
        if (dividend[15]) a_mag = ~dividend + 16'd1;
        if (divisor[7])   b_mag = ~divisor + 8'd1;
`endif
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted   = {prem[7:0], qsr[15]};
        fits      = {prem, qsr[15]} >= {2'b00, dvs};
        prem_step = fits ? (shifted - {1'b0, dvs}) : shifted;
        qsr_step  = {qsr[14:0], fits};
        q_final   = qsr_step;
        r_final   = prem_step[7:0];
`ifdef DIV_SIGNED_EN
        if (neg_q) q_final = ~qsr_step + 16'd1;
        if (neg_r) r_final = ~prem_step[7:0] + 8'd1;
`endif
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (divisor == 8'd0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge cr) begin
        if (!cr) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            prem      <= '0;
            qsr       <= '0;
            dvs       <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            if (accept) begin
                prem <= '0;
                qsr  <= a_mag;
                dvs  <= b_mag;
                cnt  <= '0;
`ifdef DIV_SIGNED_EN
                neg_q <= dividend[15] ^ divisor[7];
                neg_r <= dividend[15];
`endif
                // Divide-by-zero skips RUN; results land on the edge that raises done.
                if (divisor == 8'd0) begin
                    quotient  <= 16'hFFFF;
                    remainder <= dividend[7:0];
                    div_zero  <= 1'b1;
                end
            end else if (state == RUN) begin
                prem <= prem_step;
                qsr  <= qsr_step;
                cnt  <= cnt + 5'd1;
                if (last) begin
                    quotient  <= q_final;
                    remainder <= r_final;
                    div_zero  <= 1'b0;
                end
            end
        end
    end

endmodule
